// File: rtl/rotator_arbiter.sv
// rotator_arbiter: round-robin arbiter sharing one 8-bit rotate-right unit between two requesters,
// with a registered valid/ready response and a wrapping completed-operation count.
module rotator_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_data,
  input  logic [2:0] req0_amnt,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_data,
  input  logic [2:0] req1_amnt,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_id,
  output logic       busy,
  output logic [7:0] ops_cnt
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t     state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic [7:0] op_data_q, op_data_d;
  logic [2:0] op_amnt_q, op_amnt_d;
  logic       op_id_q, op_id_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       rsp_id_q, rsp_id_d;
  logic [7:0] ops_cnt_q, ops_cnt_d;
  logic       gnt;
  logic [7:0] rot;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      op_data_q    <= '0;
      op_amnt_q    <= '0;
      op_id_q      <= 1'b0;
      rsp_data_q   <= '0;
      rsp_id_q     <= 1'b0;
      ops_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_data_q    <= op_data_d;
      op_amnt_q    <= op_amnt_d;
      op_id_q      <= op_id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
      ops_cnt_q    <= ops_cnt_d;
    end
  always_comb begin
    gnt          = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
    req0_ready   = (state_q == IDLE) & req0_valid & ~gnt;
    req1_ready   = (state_q == IDLE) & req1_valid & gnt;
    rot          = 8'({op_data_q, op_data_q} >> op_amnt_q);
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_data_d    = op_data_q;
    op_amnt_d    = op_amnt_q;
    op_id_d      = op_id_q;
    rsp_data_d   = rsp_data_q;
    rsp_id_d     = rsp_id_q;
    ops_cnt_d    = ops_cnt_q;
    case (state_q)
      IDLE: if (req0_ready | req1_ready) begin
        op_data_d    = gnt ? req1_data : req0_data;
        op_amnt_d    = gnt ? req1_amnt : req0_amnt;
        op_id_d      = gnt;
        last_grant_d = gnt;
        state_d      = EXEC;
      end
      EXEC: begin
        rsp_data_d = rot;
        rsp_id_d   = op_id_q;
        state_d    = RESP;
      end
      RESP: if (rsp_ready) begin
        ops_cnt_d = ops_cnt_q + 8'd1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = (state_q != IDLE);
  assign ops_cnt   = ops_cnt_q;
endmodule

// File: tb/tb_rotator_arbiter.sv
// tb_rotator_arbiter: directed vectors with hand-computed results for rotator_arbiter.
module tb_rotator_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b0;
  logic       req0_ready, req1_ready, rsp_valid, rsp_id, busy;
  logic [7:0] req0_data = '0, req1_data = '0, rsp_data, ops_cnt;
  logic [2:0] req0_amnt = '0, req1_amnt = '0;
  logic [7:0] exp_cnt = '0;
  int errs = 0, checks = 0;
  always #5 clk = ~clk;
  rotator_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_amnt(req0_amnt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_amnt(req1_amnt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .busy(busy), .ops_cnt(ops_cnt)
  );
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", 8'(rsp_valid), 8'd0);
    check("rst_data", rsp_data, 8'h00);
    check("rst_id", 8'(rsp_id), 8'd0);
    check("rst_busy", 8'(busy), 8'd0);
    check("rst_cnt", ops_cnt, 8'h00);
    check("rst_rdy", 8'({req0_ready, req1_ready}), 8'd0);
    exp_cnt = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic run_op(input logic id, input logic [7:0] d, input logic [2:0] a, input logic [7:0] exp);
    @(negedge clk);
    rsp_ready = 1'b1;
    if (id) begin
      req1_valid = 1'b1; req1_data = d; req1_amnt = a;
    end else begin
      req0_valid = 1'b1; req0_data = d; req0_amnt = a;
    end
    #1;
    check("op_ready", 8'(id ? req1_ready : req0_ready), 8'd1);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    check("exec_busy", 8'(busy), 8'd1);
    check("exec_valid", 8'(rsp_valid), 8'd0);
    @(negedge clk);
    #1;
    check("rsp_valid", 8'(rsp_valid), 8'd1);
    check("rsp_data", rsp_data, exp);
    check("rsp_id", 8'(rsp_id), 8'(id));
    @(negedge clk);
    #1;
    exp_cnt++;
    check("op_cnt", ops_cnt, exp_cnt);
    check("op_idle", 8'(busy), 8'd0);
  endtask
  initial begin
    do_reset();
    run_op(1'b0, 8'h81, 3'd1, 8'hC0);
    run_op(1'b1, 8'h0F, 3'd4, 8'hF0);
    run_op(1'b0, 8'h01, 3'd3, 8'h20);
    run_op(1'b1, 8'hA5, 3'd7, 8'h4B);
    run_op(1'b0, 8'h96, 3'd0, 8'h96);
    // back-pressure: result must hold while a competing request waits
    @(negedge clk);
    rsp_ready = 1'b0;
    req1_valid = 1'b1; req1_data = 8'h3C; req1_amnt = 3'd2;
    #1 check("bp_ready", 8'(req1_ready), 8'd1);
    @(negedge clk);
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_data = 8'h55; req0_amnt = 3'd1;
    @(negedge clk);
    repeat (10) begin
      #1;
      check("bp_valid", 8'(rsp_valid), 8'd1);
      check("bp_data", rsp_data, 8'h0F);
      check("bp_id", 8'(rsp_id), 8'd1);
      check("bp_rdy", 8'({req0_ready, req1_ready}), 8'd0);
      check("bp_busy", 8'(busy), 8'd1);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    req0_valid = 1'b0;
    @(negedge clk);
    #1;
    exp_cnt++;
    check("bp_cnt", ops_cnt, exp_cnt);
    check("bp_idle", 8'(busy), 8'd0);
    // reset during EXEC, then during RESP; requester 0 used so last_grant must be restored
    @(negedge clk);
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_data = 8'h12; req0_amnt = 3'd1;
    #1 check("mr_ready", 8'(req0_ready), 8'd1);
    @(negedge clk);
    req0_valid = 1'b0;
    #1 check("mr_exec", 8'(busy), 8'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mr_e_valid", 8'(rsp_valid), 8'd0);
    check("mr_e_busy", 8'(busy), 8'd0);
    check("mr_e_cnt", ops_cnt, 8'h00);
    exp_cnt = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    req0_valid = 1'b1;
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    #1 check("mr_resp", 8'(rsp_valid), 8'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mr_r_valid", 8'(rsp_valid), 8'd0);
    check("mr_r_data", rsp_data, 8'h00);
    check("mr_r_cnt", ops_cnt, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    // contention: grants alternate starting with requester 0
    @(negedge clk);
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_data = 8'h12; req0_amnt = 3'd1;
    req1_valid = 1'b1; req1_data = 8'h34; req1_amnt = 3'd2;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("ct_rdy0", 8'(req0_ready), 8'(i % 2 == 0));
      check("ct_rdy1", 8'(req1_ready), 8'(i % 2 == 1));
      @(negedge clk);
      #1 check("ct_stall", 8'({req0_ready, req1_ready}), 8'd0);
      @(negedge clk);
      #1;
      check("ct_data", rsp_data, (i % 2 == 0) ? 8'h09 : 8'h0D);
      check("ct_id", 8'(rsp_id), 8'(i % 2 == 1));
      check("ct_stall2", 8'({req0_ready, req1_ready}), 8'd0);
      @(negedge clk);
    end
    #1 check("ct_cnt", ops_cnt, 8'd4);
    // wrap: 256 back-to-back operations at 3 cycles each
    do_reset();
    @(negedge clk);
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_data = 8'h01; req0_amnt = 3'd1;
    repeat (765) @(negedge clk);
    #1 check("wrap_ff", ops_cnt, 8'hFF);
    repeat (3) @(negedge clk);
    #1 check("wrap_00", ops_cnt, 8'h00);
    req0_valid = 1'b0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
